// File: rtl/decode_stage_hz_pkg.sv
// mini-rv instruction helpers: opcodes, decoded op enum, decode/imm
// functions and operand-usage predicates shared by the decode stage.
package instruction_utils;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [5:0] {
    I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU,
    I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
    I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU,
    I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_FENCE, I_ECALL, I_EBREAK, I_ILLEGAL
  } rv32i_instr_e;

  function automatic rv32i_instr_e decode(input logic [31:0] i);
    rv32i_instr_e t;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    t = I_ILLEGAL;
    case (i[6:0])
      OP_LUI:   t = I_LUI;
      OP_AUIPC: t = I_AUIPC;
      OP_JAL:   t = I_JAL;
      OP_JALR:  if (f3 == 3'd0) t = I_JALR;
      OP_BRANCH:
        case (f3)
          3'd0: t = I_BEQ;
          3'd1: t = I_BNE;
          3'd4: t = I_BLT;
          3'd5: t = I_BGE;
          3'd6: t = I_BLTU;
          3'd7: t = I_BGEU;
          default: t = I_ILLEGAL;
        endcase
      OP_LOAD:
        case (f3)
          3'd0: t = I_LB;
          3'd1: t = I_LH;
          3'd2: t = I_LW;
          3'd4: t = I_LBU;
          3'd5: t = I_LHU;
          default: t = I_ILLEGAL;
        endcase
      OP_STORE:
        case (f3)
          3'd0: t = I_SB;
          3'd1: t = I_SH;
          3'd2: t = I_SW;
          default: t = I_ILLEGAL;
        endcase
      OP_IMM:
        case (f3)
          3'd0: t = I_ADDI;
          3'd2: t = I_SLTI;
          3'd3: t = I_SLTIU;
          3'd4: t = I_XORI;
          3'd6: t = I_ORI;
          3'd7: t = I_ANDI;
          3'd1: if (f7 == F7_BASE) t = I_SLLI;
          default:
            if (f7 == F7_BASE) t = I_SRLI;
            else if (f7 == F7_ALT) t = I_SRAI;
        endcase
      OP_REG:
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: t = I_ADD;
            3'd1: t = I_SLL;
            3'd2: t = I_SLT;
            3'd3: t = I_SLTU;
            3'd4: t = I_XOR;
            3'd5: t = I_SRL;
            3'd6: t = I_OR;
            default: t = I_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0) t = I_SUB;
          else if (f3 == 3'd5) t = I_SRA;
        end
      OP_FENCE: t = I_FENCE;
      OP_SYSTEM:
        if (i == 32'h0000_0073) t = I_ECALL;
        else if (i == 32'h0010_0073) t = I_EBREAK;
      default: t = I_ILLEGAL;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    logic [31:0] imm;
    case (i[6:0])
      OP_LUI, OP_AUIPC:
        imm = {i[31:12], 12'd0};
      OP_JAL:
        imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
        imm = {{20{i[31]}}, i[31:20]};
      OP_STORE:
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:
        imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default:
        imm = 32'd0;
    endcase
    return imm;
  endfunction

  function automatic logic uses_rs1(input logic [31:0] i);
    return i[6:0] inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                          OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM};
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    return i[6:0] inside {OP_BRANCH, OP_STORE, OP_REG};
  endfunction

  function automatic logic writes_rd(input logic [31:0] i);
    return i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                          OP_LOAD, OP_IMM, OP_REG};
  endfunction

  // Opcode-class mnemonic as packed ASCII, for trace printers.
  function automatic logic [39:0] disassemble(input logic [31:0] i);
    logic [39:0] s;
    case (i[6:0])
      OP_LUI:    s = "lui  ";
      OP_AUIPC:  s = "auipc";
      OP_JAL:    s = "jal  ";
      OP_JALR:   s = "jalr ";
      OP_BRANCH: s = "br   ";
      OP_LOAD:   s = "load ";
      OP_STORE:  s = "store";
      OP_IMM:    s = "opimm";
      OP_REG:    s = "op   ";
      OP_FENCE:  s = "fence";
      OP_SYSTEM: s = "sys  ";
      default:   s = "ill  ";
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decode_stage_hz_rf.sv
// Register file: two combinational read ports with optional
// same-cycle write-back bypass, one write port; x0 is hardwired to 0.
module rv_reg_file #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  logic [XLEN-1:0] registers [NUM_REGS];

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    if (a == 5'd0 || {1'b0, a} >= NR) return '0;
    if (WB_BYPASS != 0 && wr_en && wr_addr == a) return wr_data;
    return registers[a[AW-1:0]];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_addr != 5'd0 && {1'b0, wr_addr} < NR)
      registers[wr_addr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage with WB bypass, load-use bubble insertion, flush
// and illegal-instruction flagging on the ID/EX register.
module decode_stage_hz
  import instruction_utils::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr_data,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic [4:0]      wb_id_rd_addr,
  input  logic            wb_id_wr_en,
  input  logic [XLEN-1:0] wb_id_rd_data,
  input  logic [4:0]      ex_id_rd_addr,
  input  logic            ex_id_is_load,
  output logic            id_ex_valid,
  output rv32i_instr_e    id_ex_instr_type,
  output logic [4:0]      id_ex_rs1_addr,
  output logic [4:0]      id_ex_rs2_addr,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [4:0]      id_ex_rd_addr,
  output logic            id_ex_write_en,
  output logic            id_ex_illegal,
  output logic            stall_if
);

  localparam logic [5:0] NR = 6'(NUM_REGS);

  typedef struct packed {
    logic            valid;
    rv32i_instr_e    itype;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } id_ex_t;

  logic [31:0]     instr;
  logic [4:0]      rs1_a;
  logic [4:0]      rs2_a;
  logic [XLEN-1:0] d1;
  logic [XLEN-1:0] d2;
  logic            hz;
  id_ex_t          nxt;
  id_ex_t          bubble;
  id_ex_t          q;

  assign instr = if_id_instr_data;

  rv_reg_file #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .WB_BYPASS (WB_BYPASS)
  ) reg_file (
    .clk      (clk),
    .rs1_addr (rs1_a),
    .rs2_addr (rs2_a),
    .rs1_data (d1),
    .rs2_data (d2),
    .wr_en    (wb_id_wr_en),
    .wr_addr  (wb_id_rd_addr),
    .wr_data  (wb_id_rd_data)
  );

  always_comb begin
    rs1_a = uses_rs1(instr) ? instr[19:15] : 5'd0;
    rs2_a = uses_rs2(instr) ? instr[24:20] : 5'd0;
    bubble = '0;
    bubble.itype = I_ADDI;
    nxt = '0;
    nxt.valid = if_id_valid;
    nxt.itype = decode(instr);
    nxt.rs1 = rs1_a;
    nxt.rs2 = rs2_a;
    nxt.d1 = d1;
    nxt.d2 = d2;
    nxt.imm = XLEN'(signed'(imm_gen(instr)));
    nxt.pc = if_id_pc;
    nxt.rd = writes_rd(instr) ? instr[11:7] : 5'd0;
    nxt.ill = (nxt.itype == I_ILLEGAL)
            | ({1'b0, rs1_a} >= NR)
            | ({1'b0, rs2_a} >= NR)
            | ({1'b0, nxt.rd} >= NR);
    nxt.we = (nxt.rd != 5'd0) & ~nxt.ill;
    // Unused sources are forced to x0, which never matches ex rd != 0.
    hz = if_id_valid & ex_id_is_load & (ex_id_rd_addr != 5'd0)
       & ((ex_id_rd_addr == rs1_a) | (ex_id_rd_addr == rs2_a));
  end

  assign stall_if = (hz | stall) & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) q <= bubble;
    else if (stall)   q <= q;
    else if (hz)      q <= bubble;
    else              q <= nxt;
  end

  assign id_ex_valid      = q.valid;
  assign id_ex_instr_type = q.itype;
  assign id_ex_rs1_addr   = q.rs1;
  assign id_ex_rs2_addr   = q.rs2;
  assign id_ex_rs1_data   = q.d1;
  assign id_ex_rs2_data   = q.d2;
  assign id_ex_imm        = q.imm;
  assign id_ex_pc         = q.pc;
  assign id_ex_rd_addr    = q.rd;
  assign id_ex_write_en   = q.we;
  assign id_ex_illegal    = q.ill;

endmodule
